// File: rtl/ascii_scroll_display_if.sv
// ascii_scroll_display_if
//   Byte-stream handshake between a text source and the scrolling display.
//   master: the text source (drives char_in / char_valid, sees char_ready)
//   slave : the display (accepts char_in / char_valid, drives char_ready)
//   char_in    - ASCII code to append
//   char_valid - char_in holds a character this cycle
//   char_ready - the display can take a character this cycle
interface ascii_scroll_display_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/ascii_scroll_display.sv
// ascii_scroll_display
//   Multi-digit ASCII text driver for the board's 7-segment displays.
//   Characters stream in over a valid/ready handshake into a text buffer.
//   The buffer is shown left-justified (static) or scrolled one character
//   per SCROLL_DIV clocks when scroll_en is high.
// Ports
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   char_if    - slave side of the character handshake
//   clear      - synchronous buffer clear (wins over a simultaneous write)
//   scroll_en  - 0 = static, 1 = scrolling
//   hex_out    - segments, digit k at [7k+6:7k], digit NUM_DIGITS-1 leftmost,
//                bit 0 = segment a
//   char_count - characters currently held
//   wrap       - one-cycle pulse when the scroll position wraps to 0
module ascii_scroll_display #(
    parameter int NUM_DIGITS = 6,
    parameter int BUF_DEPTH  = 16,
    parameter int SCROLL_DIV = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    ascii_scroll_display_if.slave              char_if,
    input  logic                               clear,
    input  logic                               scroll_en,
    output logic [7*NUM_DIGITS-1:0]            hex_out,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     char_count,
    output logic                               wrap
);

    localparam int LEN_W  = $clog2(BUF_DEPTH + 1);
    localparam int BUF_AW = $clog2(BUF_DEPTH);
    localparam int TICK_W = $clog2(SCROLL_DIV);

    localparam logic [LEN_W-1:0]  FULL_LEN  = LEN_W'(BUF_DEPTH);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCROLL_DIV - 1);
    localparam logic [6:0]        BLANK     = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        EMPTY,
        STATIC,
        SCROLL
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    len_next;
    logic [LEN_W-1:0]    pos;
    logic [TICK_W-1:0]   tick_cnt;
    logic [7:0]          text_buf [BUF_DEPTH];
    logic                accept;
    logic [7*NUM_DIGITS-1:0] hex_next;

    // Active-low glyph for one ASCII code; lower case folds onto upper case,
    // anything without a glyph is blank.
    function automatic logic [6:0] glyph(input logic [7:0] c);
        logic [7:0] u;
        logic [6:0] g;
        u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
        case (u)
            8'h30: g = 7'h40;  8'h31: g = 7'h79;  8'h32: g = 7'h24;
            8'h33: g = 7'h30;  8'h34: g = 7'h19;  8'h35: g = 7'h12;
            8'h36: g = 7'h02;  8'h37: g = 7'h78;  8'h38: g = 7'h00;
            8'h39: g = 7'h10;
            8'h41: g = 7'h08;  8'h42: g = 7'h03;  8'h43: g = 7'h46;
            8'h44: g = 7'h21;  8'h45: g = 7'h06;  8'h46: g = 7'h0E;
            8'h47: g = 7'h42;  8'h48: g = 7'h09;  8'h49: g = 7'h79;
            8'h4A: g = 7'h61;  8'h4B: g = 7'h0A;  8'h4C: g = 7'h47;
            8'h4D: g = 7'h2A;  8'h4E: g = 7'h2B;  8'h4F: g = 7'h23;
            8'h50: g = 7'h0C;  8'h51: g = 7'h18;  8'h52: g = 7'h2F;
            8'h53: g = 7'h12;  8'h54: g = 7'h07;  8'h55: g = 7'h41;
            8'h56: g = 7'h63;  8'h57: g = 7'h15;  8'h58: g = 7'h09;
            8'h59: g = 7'h11;  8'h5A: g = 7'h24;
            8'h2D: g = 7'h3F;
            default: g = 7'h7F;
        endcase
        glyph = (ACTIVE_LOW != 0) ? g : ~g;
    endfunction

    // ready drops during reset and clear so a clear always beats a write
    assign char_if.char_ready = !reset && !clear && (len < FULL_LEN);
    assign accept             = char_if.char_valid && char_if.char_ready;
    assign char_count         = len;

    // Next length and next state; the state tracks the length the buffer
    // will hold after this edge, so a clear lands directly in EMPTY.
    always_comb begin
        len_next   = len;
        next_state = state;
        if (clear) begin
            len_next = '0;
        end else if (accept) begin
            len_next = len + LEN_W'(1);
        end
        if (len_next == '0) begin
            next_state = EMPTY;
        end else if (scroll_en) begin
            next_state = SCROLL;
        end else begin
            next_state = STATIC;
        end
    end

    // Build the next frame from the current buffer, length and position;
    // registering it gives the one-cycle display latency.
    always_comb begin : render
        int idx;
        idx      = 0;
        hex_next = {NUM_DIGITS{BLANK}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            idx = int'(pos) + (NUM_DIGITS - 1 - k);
            if (idx < int'(len)) begin
                hex_next[7*k +: 7] = glyph(text_buf[BUF_AW'(idx)]);
            end
        end
    end

    // Control state. Outside SCROLL the position and tick counter are held
    // at 0, so entering SCROLL always starts a full SCROLL_DIV period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            len      <= '0;
            pos      <= '0;
            tick_cnt <= '0;
            wrap     <= 1'b0;
            hex_out  <= {NUM_DIGITS{BLANK}};
        end else begin
            state   <= next_state;
            len     <= len_next;
            wrap    <= 1'b0;
            hex_out <= hex_next;
            if (next_state != SCROLL) begin
                pos      <= '0;
                tick_cnt <= '0;
            end else if (state == SCROLL) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    if (pos == len - LEN_W'(1)) begin
                        pos  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        pos <= pos + LEN_W'(1);
                    end
                end else begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end
            end
        end
    end

    // Text storage needs no reset: only entries below len are ever shown.
    always_ff @(posedge clk) begin
        if (accept) begin
            text_buf[BUF_AW'(len)] <= char_if.char_in;
        end
    end

endmodule

// File: tb/tb_ascii_scroll_display.sv
// tb_ascii_scroll_display
//   Directed bench for ascii_scroll_display (6 digits, 16-char buffer,
//   SCROLL_DIV=4, active-low). Expected values are queued as stimulus is
//   applied and compared when the outputs are sampled.
module tb_ascii_scroll_display;

    localparam int NUM_DIGITS = 6;
    localparam int BUF_DEPTH  = 16;
    localparam int SCROLL_DIV = 4;

    localparam logic [41:0] ALL_BLANK = 42'h3FFFFFFFFFF;

    localparam logic [6:0] NUM_TAB [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] LET_TAB [26] = '{
        7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09, 7'h79,
        7'h61, 7'h0A, 7'h47, 7'h2A, 7'h2B, 7'h23, 7'h0C, 7'h18, 7'h2F,
        7'h12, 7'h07, 7'h41, 7'h63, 7'h15, 7'h09, 7'h11, 7'h24
    };

    localparam int K_HEX   = 0;
    localparam int K_COUNT = 1;
    localparam int K_READY = 2;
    localparam int K_WRAP  = 3;
    localparam int K_LEFT  = 4;

    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] value;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        scroll_en;
    logic [41:0] hex_out;
    logic [4:0]  char_count;
    logic        wrap;

    int   checks;
    int   errors;
    exp_t sb[$];

    ascii_scroll_display_if tb_if ();

    ascii_scroll_display #(
        .NUM_DIGITS (NUM_DIGITS),
        .BUF_DEPTH  (BUF_DEPTH),
        .SCROLL_DIV (SCROLL_DIV),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .char_if    (tb_if.slave),
        .clear      (clear),
        .scroll_en  (scroll_en),
        .hex_out    (hex_out),
        .char_count (char_count),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] tbGlyph(logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
        if (u >= 8'h30 && u <= 8'h39) return NUM_TAB[int'(u) - 48];
        if (u >= 8'h41 && u <= 8'h5A) return LET_TAB[int'(u) - 65];
        if (u == 8'h2D) return 7'h3F;
        return 7'h7F;
    endfunction

    // Frame expected when the text is shown starting at position p
    function automatic logic [41:0] expHex(string txt, int p);
        logic [41:0] h;
        int idx;
        h = ALL_BLANK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            idx = p + (NUM_DIGITS - 1 - k);
            if (idx < txt.len()) h[7*k +: 7] = tbGlyph(txt[idx]);
        end
        return h;
    endfunction

    task automatic pushExpect(string tag, int kind, logic [63:0] value);
        exp_t e;
        e.tag   = tag;
        e.kind  = kind;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One character per cycle on the handshake
    task automatic applyStimulus(string s);
        for (int i = 0; i < s.len(); i++) begin
            tb_if.char_valid = 1'b1;
            tb_if.char_in    = s[i];
            tick();
        end
        tb_if.char_valid = 1'b0;
    endtask

    // Drain the scoreboard against the current outputs
    task automatic checkOutput();
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_HEX:   obs = 64'(hex_out);
                K_COUNT: obs = 64'(char_count);
                K_READY: obs = 64'(tb_if.char_ready);
                K_WRAP:  obs = 64'(wrap);
                default: obs = 64'(hex_out[41:35]);
            endcase
            checks++;
            assert (obs === e.value) else begin
                errors++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.value);
            end
        end
    endtask

    // Scroll cycles first..last counted from the edge that entered SCROLL;
    // the position after edge c is (c/4) mod len and the frame lags by one edge.
    task automatic scrollRun(string txt, int first, int last);
        int n;
        n = txt.len();
        for (int c = first; c <= last; c++) begin
            tick();
            pushExpect($sformatf("scroll_hex_c%0d", c), K_HEX,
                       64'(expHex(txt, ((c - 1) / SCROLL_DIV) % n)));
            pushExpect($sformatf("scroll_wrap_c%0d", c), K_WRAP,
                       64'((c % SCROLL_DIV == 0) && ((c / SCROLL_DIV) % n == 0)));
            checkOutput();
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        clear            = 1'b0;
        scroll_en        = 1'b0;
        tb_if.char_in    = 8'h00;
        tb_if.char_valid = 1'b0;

        // reset values
        tick();
        tick();
        pushExpect("reset_hex", K_HEX, 64'(ALL_BLANK));
        pushExpect("reset_count", K_COUNT, 64'd0);
        pushExpect("reset_ready", K_READY, 64'd0);
        checkOutput();
        reset = 1'b0;
        #1;
        pushExpect("ready_after_reset", K_READY, 64'd1);
        checkOutput();

        // static text with one-cycle display latency
        applyStimulus("a");
        pushExpect("latency_hex", K_HEX, 64'(ALL_BLANK));
        pushExpect("latency_count", K_COUNT, 64'd1);
        checkOutput();
        tick();
        pushExpect("a_hex", K_HEX, 64'(expHex("a", 0)));
        checkOutput();
        applyStimulus("Bc");
        tick();
        pushExpect("aBc_hex", K_HEX,
                   64'({7'h08, 7'h03, 7'h46, 7'h7F, 7'h7F, 7'h7F}));
        pushExpect("aBc_count", K_COUNT, 64'd3);
        checkOutput();

        // fill the buffer, then hold a 17th character
        applyStimulus("DEFGHIJKLMNOP");
        tb_if.char_valid = 1'b1;
        tb_if.char_in    = "Z";
        #1;
        pushExpect("full_ready", K_READY, 64'd0);
        pushExpect("full_count", K_COUNT, 64'd16);
        checkOutput();
        tick();
        tick();
        pushExpect("full_hold_count", K_COUNT, 64'd16);
        pushExpect("full_hex", K_HEX, 64'(expHex("aBcDEFGHIJKLMNOP", 0)));
        checkOutput();

        // clear together with a valid character
        tb_if.char_in = "Q";
        clear         = 1'b1;
        #1;
        pushExpect("clear_ready", K_READY, 64'd0);
        checkOutput();
        tick();
        clear            = 1'b0;
        tb_if.char_valid = 1'b0;
        pushExpect("clear_count", K_COUNT, 64'd0);
        checkOutput();
        tick();
        pushExpect("clear_hex", K_HEX, 64'(ALL_BLANK));
        checkOutput();

        // scrolling "HELLO-1"
        applyStimulus("HELLO-1");
        tick();
        pushExpect("hello_static", K_HEX, 64'(expHex("HELLO-1", 0)));
        pushExpect("hello_count", K_COUNT, 64'd7);
        checkOutput();
        scroll_en = 1'b1;
        tick();
        pushExpect("scroll_enter_hex", K_HEX, 64'(expHex("HELLO-1", 0)));
        checkOutput();
        scrollRun("HELLO-1", 1, 5);
        pushExpect("step1_left_E", K_LEFT, 64'h06);
        checkOutput();
        scrollRun("HELLO-1", 6, 25);
        pushExpect("pos6_left_1", K_LEFT, 64'h79);
        pushExpect("pos6_hex", K_HEX,
                   64'({7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}));
        checkOutput();
        scrollRun("HELLO-1", 26, 41);

        // drop scroll_en at pos 3
        scroll_en = 1'b0;
        tick();
        pushExpect("drop_hex_pos3", K_HEX, 64'(expHex("HELLO-1", 3)));
        checkOutput();
        tick();
        pushExpect("static_again", K_HEX, 64'({7'h09, 7'h06, 7'h47, 7'h47, 7'h23, 7'h3F}));
        checkOutput();
        tick();
        tick();
        tick();
        pushExpect("static_hold", K_HEX, 64'(expHex("HELLO-1", 0)));
        pushExpect("static_wrap", K_WRAP, 64'd0);
        checkOutput();

        // re-enable: first step after a full period
        scroll_en = 1'b1;
        tick();
        scrollRun("HELLO-1", 1, 6);

        // asynchronous reset between edges
        #3;
        reset = 1'b1;
        #1;
        pushExpect("async_hex", K_HEX, 64'(ALL_BLANK));
        pushExpect("async_count", K_COUNT, 64'd0);
        pushExpect("async_ready", K_READY, 64'd0);
        pushExpect("async_wrap", K_WRAP, 64'd0);
        checkOutput();
        tick();
        reset     = 1'b0;
        scroll_en = 1'b0;

        // undecodable character
        applyStimulus("#A");
        tick();
        pushExpect("hash_hex", K_HEX,
                   64'({7'h7F, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F}));
        pushExpect("hash_count", K_COUNT, 64'd2);
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascii_scroll_display.md
Name: ascii_scroll_display

Overview:
- Multi-digit ASCII text driver for the board's 7-segment displays.
- Accepts characters over a valid/ready byte stream into an internal text buffer.
- Renders the buffer either static (left-justified) or scrolling at a programmable rate.
- Sits between a text source (UART/keyboard/control FSM) and the HEX pins, and replaces per-digit combinational ASCII decoders.

Parameters:
- NUM_DIGITS, 6, number of 7-segment digits driven.
- BUF_DEPTH, 16, text buffer capacity in characters (>= NUM_DIGITS).
- SCROLL_DIV, 25000000, clock cycles per scroll step (>= 2).
- ACTIVE_LOW, 1, 1 = segment driven 0 is lit; 0 = output inverted (1 is lit).

Ports:
- clk  in  1  system clock; only clock.
- reset  in  1  asynchronous, active-high reset.
- char_in  in  8  ASCII code to append.
- char_valid  in  1  char_in valid.
- char_ready  out  1  buffer can accept a character this cycle.
- clear  in  1  synchronous buffer clear.
- scroll_en  in  1  0 = static mode, 1 = scroll mode.
- hex_out  out  7*NUM_DIGITS  segments; bits [7k+6:7k] = digit k (k=NUM_DIGITS-1 is leftmost); bit order within digit g..a (bit0 = a).
- char_count  out  $clog2(BUF_DEPTH+1)  characters currently held.
- wrap  out  1  one-cycle pulse when the scroll position wraps to 0.

Behaviour:
- Reset (async, active-high):
  - len=0, pos=0, tick counter=0, state=EMPTY, wrap=0.
  - hex_out = all digits blank (7'h7F each when ACTIVE_LOW=1).
  - char_ready=0 while reset is asserted.
- Handshake:
  - char_ready = !reset && !clear && (len < BUF_DEPTH).
  - Transfer occurs when char_valid && char_ready at a rising edge: buf[len] <= char_in, len <= len+1.
  - When full (len=BUF_DEPTH), char_ready=0; valid input is held off and no data is lost or overwritten.
- clear: at the edge, len=0, pos=0, tick counter=0, state=EMPTY. clear has priority over a simultaneous write (the char is not accepted because char_ready=0).
- Glyphs (active-low hex, g..a):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10.
  - A=08 B=03 C=46 D=21 E=06 F=0E G=42 H=09 I=79 J=61 K=0A L=47 M=2A N=2B O=23 P=0C Q=18 R=2F S=12 T=07 U=41 V=63 W=15 X=09 Y=11 Z=24.
  - Lower case maps identically to upper case. '-'=3F, space=7F.
  - Any other code is blank (7F). ACTIVE_LOW=0 drives the bitwise inverse.
- Rendering: digit k shows buf[pos + (NUM_DIGITS-1-k)] if that index < len, else blank. hex_out is registered and reflects state one cycle after the causing edge. A char accepted at edge N appears on hex_out after edge N+1.
- FSM (state registered):
  - EMPTY: len=0.
  - STATIC: len>0 && !scroll_en.
  - SCROLL: len>0 && scroll_en.
  - Transitions follow those conditions each edge; clear forces EMPTY.
- In EMPTY and STATIC: pos=0 and tick counter=0. Leaving SCROLL returns pos to 0 at the next edge.
- In SCROLL:
  - Tick counter counts 0..SCROLL_DIV-1. At SCROLL_DIV-1 it reloads 0 and pos advances.
  - pos advances to pos+1, or wraps to 0 when pos = len-1; wrap pulses for one cycle on the wrapping edge.
- Writes during SCROLL are allowed: len grows; pos and the tick counter are unaffected.
- Asserting reset mid-scroll or mid-transfer aborts immediately to reset values.

Test Plan:
- Reset with ACTIVE_LOW=1 -> hex_out = 42'h3FFFFFFFFFF (all 7F), char_count=0, char_ready=0 during reset and 1 after release.
- Static, write "aBc" -> digit5=08, digit4=03, digit3=46, digits2..0=7F, char_count=3. A char accepted at edge N is visible after edge N+1.
- Fill with BUF_DEPTH=16 chars, then hold char_valid -> char_ready=0, char_count=16, 17th char never stored. clear+valid in the same cycle -> char_count=0, nothing written.
- SCROLL_DIV=4, text "HELLO-1", scroll_en=1:
  - pos increments every 4 cycles.
  - After one step the leftmost digit shows E=06.
  - At pos=6 the leftmost shows 1=79 and the rest are blank.
  - The next step wraps pos to 0 with a single-cycle wrap=1.
- Scrolling at pos=3, drop scroll_en -> next edge pos=0, display "HELLO-" static. Re-enable -> first step after 4 cycles.
- Assert reset asynchronously mid-scroll (between clock edges) -> outputs go blank and char_count=0 without waiting for clk. Undecodable input 8'h23 ('#') -> that digit shows 7F.
